tt_um_seq_signed_div: RTL
=========================

# tt_um_seq_signed_div

Sequential 4-bit two's-complement divider, the inverse companion of the team's combinational array multiplier, packaged as a TinyTapeout user project. It captures signed dividend and divisor from the dedicated inputs on a start pulse and runs a restoring shift-subtract loop over the magnitudes, one quotient bit per cycle. It then applies sign correction and presents quotient and remainder on the dedicated outputs, with busy/done/error status on the bidirectional pins. The shared cocotb bench can check multiplier results by dividing products back.

## Interface
Parameters: none. Width is fixed at 4 bits by the pin budget.
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design selected; gates acceptance of new starts only
- ui_in  in  8  [3:0] dividend A (signed), [7:4] divisor B (signed)
- uio_in  in  8  [0] start (level; rising edge triggers); [7:1] ignored
- uo_out  out  8  registered result: [3:0] quotient Q, [7:4] remainder R
- uio_out  out  8  [1] busy, [2] done, [3] div_by_zero, [4] overflow; [0],[7:5] = 0
- uio_oe  out  8  constant 8'b0001_1110

## Operation
- Start detect: register start_q <= uio_in[0] every cycle. Trigger when uio_in[0]=1, start_q=0, ena=1 and state is IDLE or DONE. Triggers in any other state are discarded, not queued.
- FSM states:
  - IDLE: reset state.
  - DIV: counter 3..0.
  - FIX.
  - DONE: holds results.
- On trigger edge:
  - Latch A and B; record signs sA and sB.
  - Load |A| and |B| as 4-bit unsigned (|-8| = 8 = 4'b1000).
  - Clear the 5-bit partial remainder. Clear done, div_by_zero and overflow.
  - If B=0: go directly to DONE. Set Q=4'hF, R=A, div_by_zero=1.
  - Otherwise: go to DIV with count=3 and busy=1.
- DIV, each cycle:
  - Shift the next dividend magnitude bit (MSB first) into the partial remainder.
  - If partial >= |B|: subtract, quotient bit = 1. Otherwise quotient bit = 0.
  - After count 0, go to FIX.
- FIX:
  - Q = (sA^sB) ? -q : q.
  - R = sA ? -r : r. Division truncates toward zero, so R takes the sign of A.
  - overflow=1 if A=-8 and B=-1. The result wraps to Q=4'h8, R=0.
  - Register uo_out, go to DONE.
- DONE: done=1, busy=0. uo_out and flags hold until the next trigger.
- uo_out changes only on the FIX edge or the divide-by-zero trigger edge. It holds its old value while busy.
- ena=0 mid-operation does not stall the operation; it completes.
- Reset, asynchronous at any time:
  - FSM goes to IDLE, start_q=0.
  - uo_out=0x00, uio_out=0x00.
  - An in-flight operation is lost.

## Timing
- The trigger edge is E0.
- B≠0:
  - busy=1 after E0.
  - Iterations run on E1..E4; FIX runs on E5.
  - After E5: done=1, busy=0, result valid. Latency is 5 cycles from capture.
- B=0: after E0, done=1 and div_by_zero=1, with busy never asserted. Latency is 1 cycle.
- Re-trigger from DONE:
  - Allowed on any edge where the start rising condition holds.
  - done drops after that edge.
- A start held high fires exactly once. uio_in[0] must return low for at least one sampled cycle before a new trigger.
- ui_in is sampled only at E0. Later changes do not affect the running operation.
- uio_oe is constant and independent of reset.

## Test plan
- Reset: rst_n=0 -> uo_out=0x00, uio_out=0x00, uio_oe=0x1E.
- Positive divide: ui_in=0x27 (7/2), pulse start -> 5 cycles later uo_out=0x13, done=1, busy=0 for cycles E1..E4 reads busy=1.
- Sign handling:
  - 0x29 (-7/2) -> uo_out=0xFD (Q=-3, R=-1).
  - 0xB7 (7/-5) -> uo_out=0x2F (Q=-1, R=2).
  - 0x53 (3/5) -> uo_out=0x30.
- Errors:
  - 0x05 (5/0) -> one cycle later uo_out=0x5F, div_by_zero=1, busy never high.
  - 0xF8 (-8/-1) -> uo_out=0x08, overflow=1.
- Handshake:
  - Start held high for 10 cycles -> exactly one operation.
  - New start pulse while busy -> ignored, result unchanged.
  - Start with ena=0 -> no trigger.
- Reset mid-op: assert rst_n=0 at E2 of 0x27 -> outputs 0x00, state IDLE. A new start after release yields a correct result.

Source files
------------

// File: rtl/tt_um_seq_signed_div_if.sv
// Pin bundle of the TinyTapeout user-project slot used by the sequential signed divider.
// The master side drives the operands and start, and the slave side drives the result and status pins.
interface tt_um_seq_signed_div_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_seq_signed_div.sv
// 4-bit signed restoring divider. It operates on the operand magnitudes, produces one quotient bit per cycle, and applies sign correction at the end.
// Quotient and remainder use truncating division, so the remainder takes the sign of the dividend.
module tt_um_seq_signed_div (
  input  logic                          clk,
  input  logic                          rst_n,
  tt_um_seq_signed_div_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_e;

  state_e      state_q;
  logic        start_q;
  logic        sa_q, sb_q;
  logic [3:0]  a_mag_q, b_mag_q;
  logic [3:0]  quo_q;
  logic [4:0]  part_q;
  logic [1:0]  cnt_q;
  logic [7:0]  uo_q;
  logic        busy_q, done_q, dbz_q, ovf_q;

  logic [3:0]  a_in, b_in;
  logic [3:0]  a_mag_d, b_mag_d;
  logic        trigger_d;
  logic [4:0]  shifted_d;
  logic        fits_d;
  logic [4:0]  part_d;
  logic [3:0]  q_fix_d, r_fix_d;
  logic        ovf_d;

  // uio_in[7:1] has no function.
  logic unused_uio;
  assign unused_uio = &{1'b0, bus.uio_in[7:1]};

  always_comb begin
    a_in      = bus.ui_in[3:0];
    b_in      = bus.ui_in[7:4];
    a_mag_d   = a_in[3] ? 4'(-a_in) : a_in;  // |-8| wraps to 4'b1000, read as unsigned 8
    b_mag_d   = b_in[3] ? 4'(-b_in) : b_in;
    trigger_d = bus.uio_in[0] && !start_q && bus.ena &&
                (state_q == IDLE || state_q == DONE);

    // The partial remainder stays below |B| <= 8, so the shift cannot lose a set bit.
    shifted_d = 5'({part_q, a_mag_q[cnt_q]});
    fits_d    = shifted_d >= {1'b0, b_mag_q};
    part_d    = fits_d ? shifted_d - {1'b0, b_mag_q} : shifted_d;

    q_fix_d   = (sa_q ^ sb_q) ? 4'(-quo_q) : quo_q;
    r_fix_d   = sa_q ? 4'(-part_q[3:0]) : part_q[3:0];
    ovf_d     = (a_mag_q == 4'd8) && sb_q && (b_mag_q == 4'd1);
  end

  // NOTE: every register here uses non-blocking assignment. All flops then read the pre-edge values, so the result does not depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      quo_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      uo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      start_q <= bus.uio_in[0];
      case (state_q)
        IDLE, DONE: begin
          if (trigger_d) begin
            sa_q    <= a_in[3];
            sb_q    <= b_in[3];
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            quo_q   <= '0;
            part_q  <= '0;
            cnt_q   <= 2'd3;
            ovf_q   <= 1'b0;
            if (b_in == 4'd0) begin
              state_q <= DONE;
              uo_q    <= {a_in, 4'hF};
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DIV;
              dbz_q   <= 1'b0;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        DIV: begin
          part_q <= part_d;
          quo_q  <= {quo_q[2:0], fits_d};
          cnt_q  <= cnt_q - 2'd1;
          if (cnt_q == 2'd0) state_q <= FIX;
        end
        FIX: begin
          uo_q    <= {r_fix_d, q_fix_d};
          ovf_q   <= ovf_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = {3'b000, ovf_q, dbz_q, done_q, busy_q, 1'b0};
  assign bus.uio_oe  = 8'b0001_1110;

endmodule
